// File: rtl/lut_pkg.sv
// Shared types and sizing helpers for the runtime-loadable LUT bank.
// Default geometry matches the LogicNets layer this bank replaces.
package lut_pkg;

  localparam int LUT_IN_BITS  = 6;
  localparam int LUT_OUT_BITS = 1;
  localparam int LUT_NUM      = 8;

  function automatic int depth_of(input int in_bits);
    return 1 << in_bits;
  endfunction

  // Keep at least one bit so a single-LUT bank still has a legal counter.
  function automatic int idx_width(input int num_luts);
    return (num_luts > 1) ? $clog2(num_luts) : 1;
  endfunction

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

  localparam int DEPTH     = depth_of(LUT_IN_BITS);
  localparam int TOTAL     = LUT_NUM * DEPTH;
  localparam int LUT_IDX_W = idx_width(LUT_NUM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2,
    ERROR  = 2'd3
  } lut_state_e;

endpackage

// File: rtl/lut_ram_bank.sv
// One truth-table neuron: distributed RAM with a synchronous write port,
// asynchronous read, and a registered result that holds between lookups.
module lut_ram_bank
  import lut_pkg::*;
#(
  parameter int IN_BITS  = LUT_IN_BITS,
  parameter int OUT_BITS = LUT_OUT_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IN_BITS-1:0]  wr_addr,
  input  logic [OUT_BITS-1:0] wr_data,
  input  logic                rd_en,
  input  logic [IN_BITS-1:0]  rd_addr,
  output logic [OUT_BITS-1:0] rd_data
);

  localparam int BANK_DEPTH = depth_of(IN_BITS);

  logic [OUT_BITS-1:0] mem_q [BANK_DEPTH];
  logic [OUT_BITS-1:0] rd_data_q;
  logic [OUT_BITS-1:0] rd_data_d;

  // Table storage is deliberately not reset so it maps onto LUT RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/lut_table_loader.sv
// Bank of NUM_LUTS runtime-loadable truth tables: a config stream fills
// the tables beat by beat, then the bank serves one lookup per cycle.
module lut_table_loader
  import lut_pkg::*;
#(
  parameter int IN_BITS  = LUT_IN_BITS,
  parameter int OUT_BITS = LUT_OUT_BITS,
  parameter int NUM_LUTS = LUT_NUM
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [OUT_BITS-1:0]          cfg_data,
  input  logic                         cfg_last,
  input  logic                         reload,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_LUTS*IN_BITS-1:0]  in_addr,
  output logic                         out_valid,
  output logic [NUM_LUTS*OUT_BITS-1:0] out_data,
  output logic                         tbl_valid,
  output logic                         cfg_err
);

  localparam int BANK_DEPTH = depth_of(IN_BITS);
  localparam int IDX_W      = idx_width(NUM_LUTS);

  lut_state_e         state_q, state_d;
  logic [IN_BITS-1:0] addr_cnt_q, addr_cnt_d;
  logic [IDX_W-1:0]   lut_cnt_q, lut_cnt_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               tbl_valid_q, tbl_valid_d;
  logic               cfg_err_q, cfg_err_d;
  logic               out_valid_q, out_valid_d;

  logic beat_acc;
  logic lookup_acc;
  logic addr_wrap;
  logic at_last;

  // Both streams transfer on a cycle where valid and ready are high together;
  // valid never waits on ready, and a reload pulse drops any beat it meets.
  assign beat_acc   = cfg_valid & cfg_ready_q & ~reload;
  assign lookup_acc = in_valid & in_ready;
  assign in_ready   = (state_q == ACTIVE);

  assign addr_wrap = (addr_cnt_q == IN_BITS'(BANK_DEPTH - 1));
  assign at_last   = addr_wrap && (lut_cnt_q == IDX_W'(NUM_LUTS - 1));

  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    lut_cnt_d  = lut_cnt_q;

    if (reload) begin
      state_d    = IDLE;
      addr_cnt_d = '0;
      lut_cnt_d  = '0;
    end else if (beat_acc) begin
      if (addr_wrap) begin
        addr_cnt_d = '0;
        lut_cnt_d  = lut_cnt_q + 1'b1;
      end else begin
        addr_cnt_d = addr_cnt_q + 1'b1;
      end
      // A load is well formed only if cfg_last marks exactly the final beat.
      if (at_last) begin
        state_d = cfg_last ? ACTIVE : ERROR;
      end else begin
        state_d = cfg_last ? ERROR : LOAD;
      end
    end

    cfg_ready_d = (state_d == IDLE) || (state_d == LOAD);
    tbl_valid_d = (state_d == ACTIVE);
    cfg_err_d   = (state_d == ERROR);
    out_valid_d = lookup_acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_cnt_q  <= '0;
      lut_cnt_q   <= '0;
      cfg_ready_q <= 1'b0;
      tbl_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      lut_cnt_q   <= lut_cnt_d;
      cfg_ready_q <= cfg_ready_d;
      tbl_valid_q <= tbl_valid_d;
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar g = 0; g < NUM_LUTS; g++) begin : g_lut
    localparam int ADDR_LO = slice_lo(g, IN_BITS);
    localparam int DATA_LO = slice_lo(g, OUT_BITS);

    logic bank_we;
    assign bank_we = beat_acc && (lut_cnt_q == IDX_W'(g));

    lut_ram_bank #(
      .IN_BITS  (IN_BITS),
      .OUT_BITS (OUT_BITS)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bank_we),
      .wr_addr (addr_cnt_q),
      .wr_data (cfg_data),
      .rd_en   (lookup_acc),
      .rd_addr (in_addr[ADDR_LO +: IN_BITS]),
      .rd_data (out_data[DATA_LO +: OUT_BITS])
    );
  end

  assign cfg_ready = cfg_ready_q;
  assign tbl_valid = tbl_valid_q;
  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_lut_table_loader.sv
// Bench for lut_table_loader: randomized loads and lookups checked against a
// beat-indexed table model of the bank.
module tb_lut_table_loader;
  import lut_pkg::*;

  localparam int IB = LUT_IN_BITS;
  localparam int NL = LUT_NUM;
  localparam int AW = NL * IB;
  localparam int DW = NL * LUT_OUT_BITS;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [0:0]    cfg_data = '0;
  logic          cfg_last = 1'b0;
  logic          reload = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          tbl_valid;
  logic          cfg_err;

  lut_table_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .reload    (reload),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .tbl_valid (tbl_valid),
    .cfg_err   (cfg_err)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: beat k of a load lands in table k/DEPTH, entry k%DEPTH
  bit            model_tbl [NL][DEPTH];
  bit            load_src [TOTAL];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_out;

  function automatic bit t_fn(input int x);
    return (x[2:0] == 3'b011) || ((x[2:0] == 3'b010) && x[5]);
  endfunction

  function automatic logic [DW-1:0] model_lookup(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    logic [IB-1:0] idx;
    for (int i = 0; i < NL; i++) begin
      idx = a[i*IB +: IB];
      r[i] = model_tbl[i][idx];
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] all_slices(input int v);
    logic [AW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*IB +: IB] = IB'(v);
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*IB +: IB] = IB'($urandom_range(DEPTH - 1));
    return r;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic load_beats(input int first, input int stop, input int last_beat,
                            input int gap_pct);
    int waits;
    for (int k = first; k < stop; k++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        cfg_valid = 1'b0;
        cfg_data  = 1'($urandom_range(1));
        cfg_last  = 1'($urandom_range(1));
        tick();
      end
      cfg_valid = 1'b1;
      cfg_data  = load_src[k];
      cfg_last  = (k == last_beat);
      waits = 0;
      while (!cfg_ready && waits < 50) begin
        tick();
        waits++;
      end
      if (!cfg_ready) begin
        n_cmp++;
        n_fail++;
        $display("FAIL cfg_ready_timeout: beat %0d not accepted, cfg_ready=%b required 1", k, cfg_ready);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        return;
      end
      tick();
      model_tbl[k / DEPTH][k % DEPTH] = load_src[k];
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic do_lookup(input logic [AW-1:0] a, input logic [DW-1:0] exp_v, input string nm);
    in_valid = 1'b1;
    in_addr  = a;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_in_ready: got %b required 1", nm, in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== exp_v) begin
      n_fail++;
      $display("FAIL %s: out_valid=%b out_data=%h required valid=1 data=%h addr=%h",
               nm, out_valid, out_data, exp_v, a);
    end
    last_out = exp_v;
  endtask

  task automatic check_loaded(input string nm);
    n_cmp++;
    if (tbl_valid !== 1'b1 || in_ready !== 1'b1 || cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_loaded: tbl_valid=%b in_ready=%b cfg_ready=%b cfg_err=%b required 1 1 0 0",
               nm, tbl_valid, in_ready, cfg_ready, cfg_err);
    end
  endtask

  task automatic check_err(input string nm);
    n_cmp++;
    if (cfg_err !== 1'b1 || tbl_valid !== 1'b0 || in_ready !== 1'b0 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: cfg_err=%b tbl_valid=%b in_ready=%b cfg_ready=%b required 1 0 0 0",
               nm, cfg_err, tbl_valid, in_ready, cfg_ready);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (cfg_ready !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
        tbl_valid !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: cfg_ready=%b in_ready=%b out_valid=%b out_data=%h tbl_valid=%b cfg_err=%b required all 0",
               cfg_ready, in_ready, out_valid, out_data, tbl_valid, cfg_err);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (cfg_ready !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: cfg_ready=%b in_ready=%b required 1 0", cfg_ready, in_ready);
    end
  endtask

  task automatic test_full_load();
    for (int k = 0; k < TOTAL; k++) load_src[k] = t_fn(k % DEPTH);
    load_beats(0, TOTAL - 1, TOTAL - 1, 0);
    n_cmp++;
    if (tbl_valid !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL before_last_beat: tbl_valid=%b cfg_ready=%b required 0 1", tbl_valid, cfg_ready);
    end
    load_beats(TOTAL - 1, TOTAL, TOTAL - 1, 0);
    check_loaded("full_load");
    do_lookup(all_slices(3), 8'hFF, "lookup_3");
    do_lookup(all_slices(34), 8'hFF, "lookup_34");
    do_lookup(all_slices(2), 8'h00, "lookup_2");
    do_lookup(all_slices(7), 8'h00, "lookup_7");
    for (int i = 0; i < 16; i++) begin
      logic [AW-1:0] a;
      a = rand_addr();
      do_lookup(a, model_lookup(a), "lookup_rand");
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    logic [DW-1:0] exp_v;
    for (int c = 0; c < 32; c++) begin
      acc      = ($urandom_range(3) != 0);
      in_valid = acc;
      in_addr  = rand_addr();
      if (acc) exp_q.push_back(model_lookup(in_addr));
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (acc) begin
        exp_v = exp_q.pop_front();
        if (out_valid !== 1'b1 || out_data !== exp_v) begin
          n_fail++;
          $display("FAIL b2b_result: cycle %0d out_valid=%b out_data=%h required 1 %h", c, out_valid, out_data, exp_v);
        end
        last_out = exp_v;
      end else if (out_valid !== 1'b0 || out_data !== last_out) begin
        n_fail++;
        $display("FAIL b2b_hold: cycle %0d out_valid=%b out_data=%h required 0 %h", c, out_valid, out_data, last_out);
      end
    end
  endtask

  task automatic test_cfg_stall();
    for (int c = 0; c < 5; c++) begin
      cfg_valid = 1'b1;
      cfg_data  = ~model_tbl[0][c];
      cfg_last  = 1'($urandom_range(1));
      n_cmp++;
      if (cfg_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_cfg_ready: got %b required 0", cfg_ready);
      end
      tick();
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    check_loaded("after_stall");
    for (int a = 0; a < 5; a++) do_lookup(all_slices(a), model_lookup(all_slices(a)), "stall_no_write");
  endtask

  task automatic test_isolation();
    pulse_reload();
    n_cmp++;
    if (tbl_valid !== 1'b0 || in_ready !== 1'b0 || cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_idle: tbl_valid=%b in_ready=%b cfg_ready=%b cfg_err=%b required 0 0 1 0",
               tbl_valid, in_ready, cfg_ready, cfg_err);
    end
    for (int k = 0; k < TOTAL; k++) load_src[k] = ((k / DEPTH) % 2 == 1);
    load_beats(0, TOTAL, TOTAL - 1, 0);
    check_loaded("isolation");
    do_lookup(all_slices(0), 8'hAA, "isolation_addr0");
    do_lookup(rand_addr(), 8'hAA, "isolation_rand");
  endtask

  task automatic test_framing_errors();
    pulse_reload();
    for (int k = 0; k < TOTAL; k++) load_src[k] = 1'($urandom_range(1));
    load_beats(0, 101, 100, 0);
    check_err("err_early_last");
    in_valid = 1'b1;
    in_addr  = rand_addr();
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_no_lookup: out_valid=%b required 0", out_valid);
    end
    pulse_reload();
    n_cmp++;
    if (cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL err_cleared: cfg_err=%b cfg_ready=%b required 0 1", cfg_err, cfg_ready);
    end
    load_beats(0, TOTAL, -1, 0);
    check_err("err_missing_last");
  endtask

  task automatic test_backpressure();
    pulse_reload();
    for (int k = 0; k < TOTAL; k++) load_src[k] = 1'($urandom_range(1));
    load_beats(0, TOTAL, TOTAL - 1, 30);
    check_loaded("gapped_load");
    for (int a = 0; a < DEPTH; a++) do_lookup(all_slices(a), model_lookup(all_slices(a)), "gapped_sweep");
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] r;
      r = rand_addr();
      do_lookup(r, model_lookup(r), "gapped_rand");
    end
  endtask

  task automatic test_reload_lookup();
    logic [AW-1:0] a;
    logic [DW-1:0] old_v;
    a        = rand_addr();
    old_v    = model_lookup(a);
    in_valid = 1'b1;
    reload   = 1'b1;
    in_addr  = a;
    tick();
    in_valid = 1'b0;
    reload   = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== old_v) begin
      n_fail++;
      $display("FAIL reload_lookup_old: out_valid=%b out_data=%h required 1 %h", out_valid, out_data, old_v);
    end
    n_cmp++;
    if (in_ready !== 1'b0 || tbl_valid !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_state: in_ready=%b tbl_valid=%b cfg_ready=%b required 0 0 1", in_ready, tbl_valid, cfg_ready);
    end
    for (int k = 0; k < TOTAL; k++) load_src[k] = !t_fn(k % DEPTH);
    load_beats(0, TOTAL, TOTAL - 1, 0);
    check_loaded("inverted_load");
    do_lookup(all_slices(3), 8'h00, "inverted_3");
    do_lookup(all_slices(2), 8'hFF, "inverted_2");
  endtask

  task automatic test_reset_midload();
    pulse_reload();
    for (int k = 0; k < TOTAL; k++) load_src[k] = t_fn(k % DEPTH);
    load_beats(0, 200, -1, 0);
    cfg_valid = 1'b1;
    cfg_data  = load_src[200];
    rst_n     = 1'b0;
    tick();
    cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_ready !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
        tbl_valid !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_reset: cfg_ready=%b in_ready=%b out_valid=%b out_data=%h tbl_valid=%b cfg_err=%b required all 0",
               cfg_ready, in_ready, out_valid, out_data, tbl_valid, cfg_err);
    end
    rst_n = 1'b1;
    tick();
    load_beats(0, TOTAL, TOTAL - 1, 0);
    check_loaded("fresh_load");
    do_lookup(all_slices(3), 8'hFF, "fresh_3");
    do_lookup(all_slices(34), 8'hFF, "fresh_34");
    do_lookup(all_slices(7), 8'h00, "fresh_7");
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] r;
      r = rand_addr();
      do_lookup(r, model_lookup(r), "fresh_rand");
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    last_out = '0;
    test_reset();
    test_full_load();
    test_back_to_back();
    test_cfg_stall();
    test_isolation();
    test_framing_errors();
    test_backpressure();
    test_reload_lookup();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_table_loader.md
Name: lut_table_loader

Overview:
- Runtime-loadable bank of NUM_LUTS truth-table neurons; the write side of the LogicNets neuron LUT, where ROMs are currently fixed at synthesis.
- Accepts truth-table entries over a valid/ready config stream and writes them into distributed RAM.
- Serves registered lookups, one address per LUT per beat, into the quantised-net layer pipeline.
- Lets a layer be retrained or reprogrammed without re-synthesis.

Parameters:
- IN_BITS, 6, address width per LUT (fan-in × input bits).
- OUT_BITS, 1, output width per LUT entry.
- NUM_LUTS, 8, number of independent LUTs in the bank.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous active-low reset.
- cfg_valid  in  1  config beat valid.
- cfg_ready  out  1  config beat accepted when high with cfg_valid.
- cfg_data  in  OUT_BITS  one truth-table entry.
- cfg_last  in  1  marks the final beat of a full load.
- reload  in  1  single-cycle pulse; discards tables and returns to IDLE.
- in_valid  in  1  lookup request.
- in_ready  out  1  lookup accepted when high with in_valid.
- in_addr  in  NUM_LUTS*IN_BITS  packed addresses; slice i drives LUT i.
- out_valid  out  1  lookup result valid.
- out_data  out  NUM_LUTS*OUT_BITS  packed results; slice i from LUT i.
- tbl_valid  out  1  complete, well-formed table set loaded.
- cfg_err  out  1  sticky framing error.

Behaviour:
- Clock and reset: clk is the only clock; rst_n is synchronous and active-low.
- Reset values: state=IDLE; cfg_ready=0; in_ready=0; out_valid=0; out_data=0; tbl_valid=0; cfg_err=0; both counters=0. RAM contents are not cleared; they are unreachable until tbl_valid=1.
- DEPTH = 2^IN_BITS. TOTAL = NUM_LUTS*DEPTH beats per load.
- Beat mapping: beat k writes LUT k/DEPTH, entry k%DEPTH. Entry index equals the integer value of the address, LSB = address bit 0.
- Counters: addr_cnt (IN_BITS) wraps DEPTH-1 -> 0 and increments lut_cnt. lut_cnt is clog2(NUM_LUTS) wide, plus a terminal flag.
- FSM:
  - IDLE: cfg_ready=1 from the cycle after reset release. The first accepted beat writes entry 0 and moves to LOAD.
  - LOAD: cfg_ready=1; each accepted beat writes one entry.
    - cfg_last=1 on beat TOTAL-1 -> ACTIVE, tbl_valid=1 next cycle.
    - cfg_last=1 before beat TOTAL-1, or cfg_last=0 on beat TOTAL-1 -> ERROR, cfg_err=1. The beat is still written.
  - ACTIVE: cfg_ready=0; in_ready=1.
  - ERROR: cfg_ready=0; in_ready=0; tbl_valid=0; cfg_err stays high.
- Reload: a reload pulse in any state -> IDLE next cycle, with tbl_valid=0, cfg_err=0, counters=0. In IDLE, reload has no further effect.
- Special beat cases:
  - cfg_valid with cfg_ready=0 stalls; no write occurs.
  - A single-beat load (TOTAL=1) with cfg_last=1 in IDLE goes directly to ACTIVE.
- Lookup timing:
  - in_ready = (state==ACTIVE), combinational from state.
  - An accepted lookup gives out_valid=1 and out_data exactly 1 cycle later. No output backpressure. Throughput is 1 per cycle.
  - Without an accepted lookup, out_valid=0 and out_data holds its last value.
- Simultaneous reload and in_valid in ACTIVE: the lookup is accepted using the current tables and its result appears next cycle. Reload takes effect the same next cycle.
- Reset mid-LOAD: partial data is abandoned and the state returns to IDLE. The next load restarts at beat 0.
- Write/read hazard: impossible, because writes occur only in IDLE/LOAD and reads only in ACTIVE.

Decomposition:
- Shared package lut_pkg holds:
  - the state enum (IDLE, LOAD, ACTIVE, ERROR);
  - the localparams DEPTH, TOTAL and LUT_IDX_W;
  - the packed-slice helper functions.
- One sub-module, lut_ram_bank: a single LUT as a DEPTH×OUT_BITS distributed RAM with one synchronous write port, one async read and a registered output. Instantiated NUM_LUTS times via generate, with a per-instance write enable decoded from lut_cnt.

Test Plan:
- Reset and full load: load all 8 LUTs with table T, where T(x)=1 iff x[2:0]==3'b011 or (x[2:0]==3'b010 and x[5]==1); 512 beats with cfg_last on beat 511.
  -> tbl_valid=1 one cycle after beat 511.
  -> Lookups with all slices=3, 34, 2, 7 return 8'hFF, 8'hFF, 8'h00, 8'h00 respectively, each 1 cycle after acceptance.
- Per-LUT isolation: load LUT i as constant (i odd ? 1 : 0); look up address 0 -> out_data=8'hAA.
- Framing errors:
  - cfg_last on beat 100 -> cfg_err=1, tbl_valid=0, in_ready=0.
  - No cfg_last on beat 511 -> same response.
- Config backpressure: random cfg_valid gaps with ~30% duty during load -> final table identical to the gap-free load; no extra writes.
- Reload in ACTIVE with in_valid=1 in the same cycle -> that lookup returns old table data next cycle; then in_ready=0 and tbl_valid=0; a subsequent new load of the inverted T gives all slices=3 -> 8'h00.
- rst_n low at beat 200 of a load -> all outputs return to reset values; a fresh 512-beat load succeeds and lookups match.
